// File: rtl/lloyds_kernel_sequencer.sv
// Lloyd's k-means run controller: sequences the three ap_ctrl_hs
// kernels, steps block_address, and captures distortion/cycle counts.
module lloyds_kernel_sequencer #(
  parameter int N        = 128,
  parameter int D        = 3,
  parameter int B        = 16,
  parameter int NUM_ITER = 1,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk_in1,
  input  logic        reset,
  input  logic        run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        ap_start_1,
  output logic        ap_start_2,
  output logic        ap_start_3,
  input  logic        ap_ready_1,
  input  logic        ap_ready_2,
  input  logic        ap_ready_3,
  input  logic        ap_done_1,
  input  logic        ap_done_2,
  input  logic        ap_done_3,
  output logic [31:0] block_address,
  output logic [15:0] iteration,
  input  logic [31:0] distortion_out,
  input  logic        distortion_out_ap_vld,
  output logic [31:0] distortion,
  output logic [31:0] cycle_count
);

  generate
    if ((N % B) != 0 || N < B) begin : g_bad_nb
      $error("N must be a non-zero multiple of B");
    end
    if (NUM_ITER < 1) begin : g_bad_iter
      $error("NUM_ITER must be at least 1");
    end
  endgenerate

  localparam logic [31:0] LP_STEP = 32'(B * D);
  localparam logic [31:0] LP_LAST = 32'((N - B) * D);
  localparam logic [15:0] LP_ITER = 16'(NUM_ITER - 1);
  localparam logic [31:0] LP_TO   = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, START_1, WAIT_1, START_2, WAIT_2,
    NEXT_BLK, START_3, WAIT_3, FINISH, ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_st1;
  logic        r_st2;
  logic        r_st3;
  logic [31:0] r_addr;
  logic [15:0] r_iter;
  logic [31:0] r_dist;
  logic [31:0] r_cnt;
  logic [31:0] r_wd;
  logic        w_cmp1;
  logic        w_cmp2;
  logic        w_cmp3;
  logic        w_active;
  logic        w_to;
  logic        w_last_it;
  logic        w_accept;
  logic        w_st_entry;

  // A kernel completes either on its wait done, or ready+done together.
  assign w_cmp1 = ((r_state == START_1) && ap_ready_1 && ap_done_1) ||
                  ((r_state == WAIT_1) && ap_done_1);
  assign w_cmp2 = ((r_state == START_2) && ap_ready_2 && ap_done_2) ||
                  ((r_state == WAIT_2) && ap_done_2);
  assign w_cmp3 = ((r_state == START_3) && ap_ready_3 && ap_done_3) ||
                  ((r_state == WAIT_3) && ap_done_3);

  assign w_active = r_state inside {START_1, WAIT_1, START_2,
                                    WAIT_2, START_3, WAIT_3};
  assign w_to       = w_active && (r_wd >= LP_TO);
  assign w_last_it  = (r_iter == LP_ITER);
  assign w_accept   = (r_state == IDLE) && run;
  assign w_st_entry = (w_next inside {START_1, START_2, START_3}) &&
                      (w_next != r_state);

  // Next-state decode; completion wins over a coincident timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (run) w_next = START_1;
      START_1: begin
        if (w_cmp1)          w_next = START_2;
        else if (w_to)       w_next = ERR;
        else if (ap_ready_1) w_next = WAIT_1;
      end
      WAIT_1: begin
        if (w_cmp1)    w_next = START_2;
        else if (w_to) w_next = ERR;
      end
      START_2: begin
        if (w_cmp2)          w_next = NEXT_BLK;
        else if (w_to)       w_next = ERR;
        else if (ap_ready_2) w_next = WAIT_2;
      end
      WAIT_2: begin
        if (w_cmp2)    w_next = NEXT_BLK;
        else if (w_to) w_next = ERR;
      end
      NEXT_BLK: begin
        if (r_addr == LP_LAST) w_next = START_3;
        else                   w_next = START_2;
      end
      START_3: begin
        if (w_cmp3)          w_next = w_last_it ? FINISH : START_2;
        else if (w_to)       w_next = ERR;
        else if (ap_ready_3) w_next = WAIT_3;
      end
      WAIT_3: begin
        if (w_cmp3)    w_next = w_last_it ? FINISH : START_2;
        else if (w_to) w_next = ERR;
      end
      FINISH:   w_next = IDLE;
      ERR:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Registered control outputs, decoded from the upcoming state.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_st1  <= 1'b0;
      r_st2  <= 1'b0;
      r_st3  <= 1'b0;
    end else begin
      r_st1  <= (w_next == START_1);
      r_st2  <= (w_next == START_2);
      r_st3  <= (w_next == START_3);
      r_busy <= !(w_next inside {IDLE, FINISH, ERR});
      r_done <= (w_next == FINISH);
      if (w_next == ERR) r_err <= 1'b1;
      else if (w_accept) r_err <= 1'b0;
    end
  end

  // Block address, iteration, distortion capture and cycle counter.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_iter <= '0;
      r_dist <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= '0;
        r_iter <= '0;
        r_cnt  <= '0;
      end else begin
        if (r_state == NEXT_BLK)
          r_addr <= (r_addr == LP_LAST) ? '0 : r_addr + LP_STEP;
        if (w_cmp3 && !w_last_it)
          r_iter <= r_iter + 16'd1;
        if (w_active && (r_cnt != '1))
          r_cnt <= r_cnt + 32'd1;
      end
      if (r_busy && distortion_out_ap_vld)
        r_dist <= distortion_out;
    end
  end

  // Watchdog: restarts on each kernel start, runs through its wait.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset)                        r_wd <= '0;
    else if (w_st_entry)              r_wd <= '0;
    else if (w_active && r_wd != '1)  r_wd <= r_wd + 32'd1;
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_err;
  assign ap_start_1    = r_st1;
  assign ap_start_2    = r_st2;
  assign ap_start_3    = r_st3;
  assign block_address = r_addr;
  assign iteration     = r_iter;
  assign distortion    = r_dist;
  assign cycle_count   = r_cnt;

endmodule

// File: tb/tb_lloyds_kernel_sequencer.sv
// Randomized bench for lloyds_kernel_sequencer with responding
// kernel models and an event-sequence reference model.
module tb_lloyds_kernel_sequencer;

  localparam int N  = 128;
  localparam int D  = 3;
  localparam int B  = 16;
  localparam int NI = 3;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        busy, done, error;
  logic        ap_start_1, ap_start_2, ap_start_3;
  logic        ap_ready_1, ap_ready_2, ap_ready_3;
  logic        ap_done_1, ap_done_2, ap_done_3;
  logic [31:0] block_address;
  logic [15:0] iteration;
  logic [31:0] distortion_out;
  logic        distortion_out_ap_vld;
  logic [31:0] distortion;
  logic [31:0] cycle_count;

  int          errs = 0;
  int          checks = 0;
  int          exp_cc;
  logic [31:0] exp_dist;
  int          n_multi = 0;
  logic [49:0] evq[$];
  logic [2:0]  prev_st = 3'b000;

  lloyds_kernel_sequencer #(
    .N(N), .D(D), .B(B), .NUM_ITER(NI), .TIMEOUT(TO)
  ) dut (
    .clk_in1(clk),
    .reset(reset),
    .run(run),
    .busy(busy),
    .done(done),
    .error(error),
    .ap_start_1(ap_start_1),
    .ap_start_2(ap_start_2),
    .ap_start_3(ap_start_3),
    .ap_ready_1(ap_ready_1),
    .ap_ready_2(ap_ready_2),
    .ap_ready_3(ap_ready_3),
    .ap_done_1(ap_done_1),
    .ap_done_2(ap_done_2),
    .ap_done_3(ap_done_3),
    .block_address(block_address),
    .iteration(iteration),
    .distortion_out(distortion_out),
    .distortion_out_ap_vld(distortion_out_ap_vld),
    .distortion(distortion),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Log each kernel start rising edge with its address and iteration.
  always @(negedge clk) begin
    logic [2:0] st;
    st = {ap_start_3, ap_start_2, ap_start_1};
    if ($countones(st) > 1) n_multi++;
    for (int k = 0; k < 3; k++)
      if (st[k] && !prev_st[k])
        evq.push_back({2'(k + 1), iteration, block_address});
    prev_st = st;
  end

  function automatic logic start_of(input int k);
    case (k)
      1:       return ap_start_1;
      2:       return ap_start_2;
      default: return ap_start_3;
    endcase
  endfunction

  task automatic set_rdy(input int k, input logic v);
    case (k)
      1:       ap_ready_1 = v;
      2:       ap_ready_2 = v;
      default: ap_ready_3 = v;
    endcase
  endtask

  task automatic set_done(input int k, input logic v);
    case (k)
      1:       ap_done_1 = v;
      2:       ap_done_2 = v;
      default: ap_done_3 = v;
    endcase
  endtask

  task automatic clr_pulses();
    ap_done_1 = 1'b0;
    ap_done_2 = 1'b0;
    ap_done_3 = 1'b0;
    run = 1'b0;
    distortion_out_ap_vld = 1'b0;
  endtask

  task automatic drive_vld();
    distortion_out = $urandom;
    distortion_out_ap_vld = 1'b1;
    exp_dist = distortion_out;
  endtask

  // One kernel invocation: random ready delay, random done latency.
  task automatic serve(input int k, input bit stray);
    int n, r, d;
    bit same;
    n = 0;
    while (!start_of(k)) begin
      n++;
      if (n > 200) begin
        chk($sformatf("k%0d_start_seen", k), 0, 1);
        return;
      end
      @(negedge clk);
    end
    n = 1;
    r = $urandom_range(0, 4);
    d = $urandom_range(1, 20);
    same = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < r; i++) begin
      @(negedge clk);
      n++;
      chk($sformatf("k%0d_start_held", k), start_of(k), 1);
    end
    set_rdy(k, 1'b1);
    if (same) begin
      set_done(k, 1'b1);
      if (k == 3) drive_vld();
    end
    @(negedge clk);
    set_rdy(k, 1'b0);
    clr_pulses();
    chk($sformatf("k%0d_start_drop", k), start_of(k), 0);
    if (!same) begin
      for (int i = 1; i <= d; i++) begin
        n++;
        if (stray && k == 2) begin
          if ($urandom_range(0, 3) == 0) ap_done_3 = 1'b1;
          if ($urandom_range(0, 3) == 0) ap_done_1 = 1'b1;
          if ($urandom_range(0, 5) == 0) run = 1'b1;
        end
        if (k == 3 && i == 1) drive_vld();
        if (i == d) begin
          set_done(k, 1'b1);
          if (k == 3 && $urandom_range(0, 1) == 1) drive_vld();
        end
        @(negedge clk);
        clr_pulses();
      end
    end
    exp_cc += n;
  endtask

  task automatic pulse_run();
    evq.delete();
    exp_cc = 0;
    n_multi = 0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Full run compared against the expected start sequence.
  task automatic run_seq();
    logic [49:0] m[$];
    int w;
    pulse_run();
    chk("accept_busy", busy, 1);
    chk("accept_err_clr", error, 0);
    chk("accept_cc_clr", cycle_count, 0);
    serve(1, 1'b0);
    for (int it = 0; it < NI; it++) begin
      for (int b = 0; b < N / B; b++) serve(2, 1'b1);
      serve(3, 1'b0);
    end
    w = 0;
    while (!done && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("distortion", distortion, exp_dist);
    chk("cycle_count", cycle_count, exp_cc);
    chk("end_addr", block_address, 0);
    chk("end_iter", iteration, NI - 1);
    chk("end_err", error, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    m.push_back({2'd1, 16'd0, 32'd0});
    for (int it = 0; it < NI; it++) begin
      for (int b = 0; b < N / B; b++)
        m.push_back({2'd2, 16'(it), 32'(b * B * D)});
      m.push_back({2'd3, 16'(it), 32'd0});
    end
    chk("n_events", evq.size(), m.size());
    for (int i = 0; i < m.size() && i < evq.size(); i++)
      chk($sformatf("ev%0d", i), evq[i], m[i]);
    chk("onehot_start", n_multi, 0);
    distortion_out = ~exp_dist;
    distortion_out_ap_vld = 1'b1;
    @(negedge clk);
    distortion_out_ap_vld = 1'b0;
    @(negedge clk);
    chk("idle_vld_ignored", distortion, exp_dist);
  endtask

  task automatic timeout_test();
    int n;
    pulse_run();
    serve(1, 1'b0);
    n = 0;
    while (!ap_start_2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_start2", ap_start_2, 1);
    ap_ready_2 = 1'b1;
    n = 0;
    while (!error && n < 300) begin
      @(negedge clk);
      ap_ready_2 = 1'b0;
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_busy", busy, 0);
    chk("to_starts", {ap_start_3, ap_start_2, ap_start_1}, 0);
    chk("to_cc", cycle_count, exp_cc + TO);
    @(negedge clk);
    chk("to_err_sticky", error, 1);
    chk("to_idle_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("to_err_hold", error, 1);
  endtask

  task automatic reset_test();
    int n;
    pulse_run();
    serve(1, 1'b0);
    for (int b = 0; b < 3; b++) serve(2, 1'b0);
    n = 0;
    while (!ap_start_2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_addr144", block_address, 144);
    ap_ready_2 = 1'b1;
    @(negedge clk);
    ap_ready_2 = 1'b0;
    @(negedge clk);
    chk("rst_in_wait2", busy && !ap_start_2, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_ctrl", {busy, done, error, ap_start_1, ap_start_2,
                     ap_start_3, iteration}, 0);
    chk("rst_addr_cc", {block_address, cycle_count}, 0);
    chk("rst_dist", distortion, 0);
    exp_dist = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clr_pulses();
    ap_ready_1 = 1'b0;
    ap_ready_2 = 1'b0;
    ap_ready_3 = 1'b0;
    distortion_out = '0;
    exp_dist = '0;
    exp_cc = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, error, ap_start_1, ap_start_2,
                       ap_start_3, iteration}, 0);
    chk("reset_addr_cc", {block_address, cycle_count}, 0);
    chk("reset_dist", distortion, 0);
    reset = 1'b0;
    @(negedge clk);
    run_seq();
    timeout_test();
    run_seq();
    reset_test();
    run_seq();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
